pixel_stream_reader: RTL



---
 rtl/pix_pkg.sv | 17 +
 rtl/pix_skid_buf.sv | 62 ++++++
 rtl/pixel_stream_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/pix_pkg.sv
// rtl/pix_pkg.sv - shared widths, word types and reader FSM states
package pix_pkg;

    localparam int PIX_W  = 8;
    localparam int DATA_W = 32;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/pix_skid_buf.sv
// rtl/pix_skid_buf.sv - two-entry register FIFO absorbing read latency under backpressure
module pix_skid_buf
    import pix_pkg::*;
#(
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             do_pop;

    // A pop against an empty buffer is meaningless, so it is dropped here.
    assign do_pop = pop && (occ != 2'd0);
    assign head   = entry0;

    // entry0 is always the head; entry1 only holds data while occ==2.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The reader's issue rule must never let a third pixel arrive while two are held.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (occ == 2'd2)));

endmodule

// File: rtl/pixel_stream_reader.sv
// rtl/pixel_stream_reader.sv - streams one frame of pixels from a synchronous memory as 32-bit words
module pixel_stream_reader #(
    parameter int PIX_COUNT = 11,
    parameter int ADDR_W    = 4,
    parameter int PIX_W     = pix_pkg::PIX_W,
    parameter int DATA_W    = pix_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIX_COUNT - 1);

    pix_pkg::rd_state_t state;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] out_idx;
    logic              inflight;
    logic              xfer;
    logic [1:0]        occ;
    logic [2:0]        level;
    logic [PIX_W-1:0]  head;

    pix_skid_buf #(
        .WIDTH (PIX_W)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (mem_rdata),
        .pop  (xfer),
        .head (head),
        .occ  (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign out_data  = DATA_W'(head);
    assign out_last  = out_valid && (out_idx == LAST_IDX);
    assign xfer      = out_valid && out_ready;
    assign mem_addr  = rd_addr;

    // Pixels held plus the one still coming back from memory.
    assign level = {1'b0, occ} + {2'b00, inflight};

    // Issue a read only when the skid buffer is guaranteed room for its data.
    always_comb begin
        mem_rd_en = 1'b0;
        if (state == pix_pkg::RUN) begin
            mem_rd_en = (level < 3'd2) || ((level == 3'd2) && xfer);
        end
    end

    // Frame FSM with read address, output index, in-flight flag and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= pix_pkg::IDLE;
            rd_addr  <= '0;
            out_idx  <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            done     <= 1'b0;
            if (xfer) begin
                out_idx <= out_idx + ADDR_W'(1);
            end
            case (state)
                pix_pkg::IDLE: begin
                    if (start) begin
                        state   <= pix_pkg::RUN;
                        rd_addr <= '0;
                        out_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                pix_pkg::RUN: begin
                    if (mem_rd_en) begin
                        if (rd_addr == LAST_IDX) begin
                            state <= pix_pkg::DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                pix_pkg::DRAIN: begin
                    if (xfer && out_last) begin
                        state <= pix_pkg::DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                pix_pkg::DONE: begin
                    state   <= pix_pkg::IDLE;
                    rd_addr <= '0;
                end
                default: begin
                    state <= pix_pkg::IDLE;
                end
            endcase
        end
    end

endmodule
